// File: rtl/ctrl_pkg.sv
// -----------------------------------------------------------------------------
// ctrl_pkg
// Shared definitions for the multicycle RV64 control unit: state encoding,
// opcode constants, datapath mux/ALU/immediate encodings, trap causes and the
// instruction decode function used by S_DECODE.
// The immediate extender uses the same IMM_* constants.
// -----------------------------------------------------------------------------
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_EXEC_R = 4'd3,
        S_EXEC_I = 4'd4,
        S_EXEC_U = 4'd5,
        S_ALU_WB = 4'd6,
        S_ADDR   = 4'd7,
        S_MEM_LD = 4'd8,
        S_LD_WB  = 4'd9,
        S_MEM_SD = 4'd10,
        S_BRANCH = 4'd11,
        S_TRAP   = 4'd12
    } state_t;

    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_ADDI = 7'b0010011;
    localparam logic [6:0] OP_LUI  = 7'b0110111;
    localparam logic [6:0] OP_LD   = 7'b0000011;
    localparam logic [6:0] OP_SD   = 7'b0100011;
    localparam logic [6:0] OP_BR   = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_D   = 3'b011;
    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [6:0] F7_ADD = 7'b0000000;
    localparam logic [6:0] F7_SUB = 7'b0100000;

    localparam logic [1:0] SRC_A_PC    = 2'd0;
    localparam logic [1:0] SRC_A_REG   = 2'd1;
    localparam logic [1:0] SRC_A_OLDPC = 2'd2;
    localparam logic [1:0] SRC_A_ZERO  = 2'd3;

    localparam logic [1:0] SRC_B_REG  = 2'd0;
    localparam logic [1:0] SRC_B_FOUR = 2'd1;
    localparam logic [1:0] SRC_B_IMM  = 2'd2;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_S = 3'd1;
    localparam logic [2:0] IMM_B = 3'd2;
    localparam logic [2:0] IMM_U = 3'd3;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'd0,
        CAUSE_ILLEGAL = 2'd1,
        CAUSE_TIMEOUT = 2'd2
    } trap_cause_t;

    // Successor of S_DECODE for the given IR fields; unsupported encodings
    // return S_TRAP.
    function automatic state_t decode_next(input logic [6:0] op,
                                           input logic [2:0] f3,
                                           input logic [6:0] f7);
        state_t s;
        s = S_TRAP;
        case (op)
            OP_R:    if (f3 == F3_ADD && (f7 == F7_ADD || f7 == F7_SUB)) s = S_EXEC_R;
            OP_ADDI: if (f3 == F3_ADD) s = S_EXEC_I;
            OP_LUI:  s = S_EXEC_U;
            OP_LD,
            OP_SD:   if (f3 == F3_D) s = S_ADDR;
            OP_BR:   if (f3 == F3_BEQ || f3 == F3_BNE) s = S_BRANCH;
            default: s = S_TRAP;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/main_control_fsm_if.sv
// -----------------------------------------------------------------------------
// main_control_fsm_if
// Memory request/ready handshake between the control unit and unified memory.
//   mem_req   : access request (control -> memory)
//   mem_wr    : 1 = write, 0 = read; valid with mem_req (control -> memory)
//   mem_ready : memory completes the current access this cycle (memory -> control)
// -----------------------------------------------------------------------------
interface main_control_fsm_if;
    logic mem_req;
    logic mem_wr;
    logic mem_ready;

    modport master (output mem_req, output mem_wr, input mem_ready);
    modport slave  (input mem_req, input mem_wr, output mem_ready);
endinterface

// File: rtl/main_control_fsm_mem_timeout_ctr.sv
// -----------------------------------------------------------------------------
// mem_timeout_ctr
// Watchdog for a single memory access. Counts consecutive stalled cycles and
// flags expiry on the stall cycle that brings the count to MEM_TIMEOUT.
// A cycle with mem_ready high is not a stall, so a late ready always wins.
// MEM_TIMEOUT = 0 disables expiry.
//   clk, rst_n : clock, asynchronous active-low reset
//   i_clear    : restart counting (new access begins)
//   i_stall    : request outstanding and memory not ready this cycle
//   o_expired  : this stall cycle is the MEM_TIMEOUT-th in a row
// -----------------------------------------------------------------------------
module mem_timeout_ctr #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_stall,
    output logic o_expired
);

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] LAST = CW'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    logic [CW-1:0] r_cnt;
    logic          w_hit;

    assign w_hit     = (r_cnt == LAST);
    assign o_expired = (MEM_TIMEOUT != 0) && i_stall && w_hit;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_stall) begin
            r_cnt <= w_hit ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/main_control_fsm.sv
// -----------------------------------------------------------------------------
// main_control_fsm
// Multicycle control unit for the RV64 core. Sequences PC, IR, register file,
// ALU, ALUOut, MDR, immediate extender and unified memory one instruction at a
// time. Illegal instructions and memory timeouts park it in sticky S_TRAP.
//   clk, rst_n          : clock, asynchronous active-low reset
//   opcode/funct3/funct7: IR fields (stable from S_DECODE to next S_FETCH)
//   alu_zero            : ALU result == 0
//   mem (master)        : mem_req / mem_wr out, mem_ready in
//   ir_wr, pc_wr, pc_src, alu_src_a, alu_src_b, alu_op, imm_sel,
//   alu_out_wr, mdr_wr, reg_wr, mem_to_reg : datapath controls
//   trap, trap_cause    : sticky trap flag and its cause
//   state_dbg           : current state encoding
// -----------------------------------------------------------------------------
module main_control_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [6:0]          opcode,
    input  logic [2:0]          funct3,
    input  logic [6:0]          funct7,
    input  logic                alu_zero,
    main_control_fsm_if.master  mem,
    output logic                ir_wr,
    output logic                pc_wr,
    output logic                pc_src,
    output logic [1:0]          alu_src_a,
    output logic [1:0]          alu_src_b,
    output logic [2:0]          alu_op,
    output logic [2:0]          imm_sel,
    output logic                alu_out_wr,
    output logic                mdr_wr,
    output logic                reg_wr,
    output logic                mem_to_reg,
    output logic                trap,
    output logic [1:0]          trap_cause,
    output logic [3:0]          state_dbg
);

    state_t      r_state, w_next;
    trap_cause_t r_trap_cause, w_trap_cause_next;

    logic w_mem_req, w_mem_wr;
    logic w_stall, w_clear, w_expired;

    assign mem.mem_req = w_mem_req;
    assign mem.mem_wr  = w_mem_wr;
    assign state_dbg   = r_state;

    // Any state change starts a fresh access window for the watchdog; stalls
    // only ever occur while the FSM holds in a memory state.
    assign w_stall = w_mem_req & ~mem.mem_ready;
    assign w_clear = (w_next != r_state);

    mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_clear   (w_clear),
        .i_stall   (w_stall),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_RESET;
            r_trap_cause <= CAUSE_NONE;
        end else begin
            r_state      <= w_next;
            r_trap_cause <= w_trap_cause_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path leaves
        // a signal unassigned, which would infer a latch.
        w_next            = r_state;
        w_trap_cause_next = r_trap_cause;
        w_mem_req         = 1'b0;
        w_mem_wr          = 1'b0;
        ir_wr             = 1'b0;
        pc_wr             = 1'b0;
        pc_src            = 1'b0;
        alu_src_a         = SRC_A_PC;
        alu_src_b         = SRC_B_REG;
        alu_op            = ALU_ADD;
        imm_sel           = IMM_I;
        alu_out_wr        = 1'b0;
        mdr_wr            = 1'b0;
        reg_wr            = 1'b0;
        mem_to_reg        = 1'b0;
        trap              = 1'b0;
        trap_cause        = CAUSE_NONE;

        case (r_state)
            S_RESET: w_next = S_FETCH;

            S_FETCH: begin
                w_mem_req = 1'b1;
                alu_src_a = SRC_A_PC;
                alu_src_b = SRC_B_FOUR;
                alu_op    = ALU_ADD;
                if (mem.mem_ready) begin
                    ir_wr  = 1'b1;
                    pc_wr  = 1'b1;
                    w_next = S_DECODE;
                end else if (w_expired) begin
                    w_next            = S_TRAP;
                    w_trap_cause_next = CAUSE_TIMEOUT;
                end
            end

            S_DECODE: begin
                // Speculatively compute the branch target into ALUOut.
                alu_src_a  = SRC_A_OLDPC;
                alu_src_b  = SRC_B_IMM;
                imm_sel    = IMM_B;
                alu_out_wr = 1'b1;
                w_next     = decode_next(opcode, funct3, funct7);
                if (w_next == S_TRAP) w_trap_cause_next = CAUSE_ILLEGAL;
            end

            S_EXEC_R: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_REG;
                alu_op     = funct7[5] ? ALU_SUB : ALU_ADD;
                alu_out_wr = 1'b1;
                w_next     = S_ALU_WB;
            end

            S_EXEC_I: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_IMM;
                imm_sel    = IMM_I;
                alu_out_wr = 1'b1;
                w_next     = S_ALU_WB;
            end

            S_EXEC_U: begin
                alu_src_a  = SRC_A_ZERO;
                alu_src_b  = SRC_B_IMM;
                imm_sel    = IMM_U;
                alu_out_wr = 1'b1;
                w_next     = S_ALU_WB;
            end

            S_ALU_WB: begin
                reg_wr = 1'b1;
                w_next = S_FETCH;
            end

            S_ADDR: begin
                alu_src_a  = SRC_A_REG;
                alu_src_b  = SRC_B_IMM;
                imm_sel    = (opcode == OP_LD) ? IMM_I : IMM_S;
                alu_out_wr = 1'b1;
                w_next     = (opcode == OP_LD) ? S_MEM_LD : S_MEM_SD;
            end

            S_MEM_LD: begin
                w_mem_req = 1'b1;
                if (mem.mem_ready) begin
                    mdr_wr = 1'b1;
                    w_next = S_LD_WB;
                end else if (w_expired) begin
                    w_next            = S_TRAP;
                    w_trap_cause_next = CAUSE_TIMEOUT;
                end
            end

            S_LD_WB: begin
                reg_wr     = 1'b1;
                mem_to_reg = 1'b1;
                w_next     = S_FETCH;
            end

            S_MEM_SD: begin
                w_mem_req = 1'b1;
                w_mem_wr  = 1'b1;
                if (mem.mem_ready) begin
                    w_next = S_FETCH;
                end else if (w_expired) begin
                    w_next            = S_TRAP;
                    w_trap_cause_next = CAUSE_TIMEOUT;
                end
            end

            S_BRANCH: begin
                alu_src_a = SRC_A_REG;
                alu_src_b = SRC_B_REG;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_wr     = ((funct3 == F3_BEQ) &  alu_zero) |
                            ((funct3 == F3_BNE) & ~alu_zero);
                w_next    = S_FETCH;
            end

            S_TRAP: begin
                trap       = 1'b1;
                trap_cause = r_trap_cause;
            end

            default: w_next = S_RESET;
        endcase
    end

endmodule

// File: tb/tb_main_control_fsm.sv
// -----------------------------------------------------------------------------
// tb_main_control_fsm
// Directed bench for main_control_fsm: ADDI, LD with wait states, R-type SUB,
// BEQ/BNE, illegal opcode trap, fetch timeout trap and its ready-wins corner,
// and reset asserted in the middle of a store.
// -----------------------------------------------------------------------------
module tb_main_control_fsm;

    localparam logic [3:0] ST_RESET  = 4'd0;
    localparam logic [3:0] ST_FETCH  = 4'd1;
    localparam logic [3:0] ST_DECODE = 4'd2;
    localparam logic [3:0] ST_EXEC_R = 4'd3;
    localparam logic [3:0] ST_EXEC_I = 4'd4;
    localparam logic [3:0] ST_ALU_WB = 4'd6;
    localparam logic [3:0] ST_ADDR   = 4'd7;
    localparam logic [3:0] ST_MEM_LD = 4'd8;
    localparam logic [3:0] ST_LD_WB  = 4'd9;
    localparam logic [3:0] ST_MEM_SD = 4'd10;
    localparam logic [3:0] ST_BRANCH = 4'd11;
    localparam logic [3:0] ST_TRAP   = 4'd12;

    logic       clk;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       alu_zero;
    logic       ir_wr, pc_wr, pc_src, alu_out_wr, mdr_wr, reg_wr, mem_to_reg, trap;
    logic [1:0] alu_src_a, alu_src_b, trap_cause;
    logic [2:0] alu_op, imm_sel;
    logic [3:0] state_dbg;

    int total = 0;
    int bad   = 0;

    main_control_fsm_if u_if ();

    main_control_fsm #(.MEM_TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .alu_zero   (alu_zero),
        .mem        (u_if),
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .pc_src     (pc_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .imm_sel    (imm_sel),
        .alu_out_wr (alu_out_wr),
        .mdr_wr     (mdr_wr),
        .reg_wr     (reg_wr),
        .mem_to_reg (mem_to_reg),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state_dbg  (state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock and settle 2 time units past the rising edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic set_ir(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7);
        opcode = op;
        funct3 = f3;
        funct7 = f7;
    endtask

    task automatic reset_pulse();
        rst_n = 1'b0;
        #1;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        alu_zero        = 1'b0;
        u_if.mem_ready  = 1'b1;
        set_ir(7'b0010011, 3'b000, 7'b0000000);   // ADDI x1,x0,5
        #12;
        chk("rst_state",   state_dbg, ST_RESET);
        chk("rst_mem_req", u_if.mem_req, 0);
        chk("rst_trap",    trap, 0);
        chk("rst_pc_wr",   pc_wr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_hold_then", state_dbg, ST_FETCH);

        // ---- ADDI: FETCH, DECODE, EXEC_I, ALU_WB ----
        chk("addi_f_ir_wr",  ir_wr, 1);
        chk("addi_f_pc_wr",  pc_wr, 1);
        chk("addi_f_src_b",  alu_src_b, 1);
        chk("addi_f_reg_wr", reg_wr, 0);
        tick();
        chk("addi_d_state",  state_dbg, ST_DECODE);
        chk("addi_d_src_a",  alu_src_a, 2);
        chk("addi_d_imm",    imm_sel, 2);
        chk("addi_d_aowr",   alu_out_wr, 1);
        chk("addi_d_pc_wr",  pc_wr, 0);
        chk("addi_d_ir_wr",  ir_wr, 0);
        tick();
        chk("addi_x_state",  state_dbg, ST_EXEC_I);
        chk("addi_x_src_a",  alu_src_a, 1);
        chk("addi_x_src_b",  alu_src_b, 2);
        chk("addi_x_imm",    imm_sel, 0);
        chk("addi_x_reg_wr", reg_wr, 0);
        tick();
        chk("addi_wb_state", state_dbg, ST_ALU_WB);
        chk("addi_wb_reg_wr", reg_wr, 1);
        chk("addi_wb_m2r",   mem_to_reg, 0);
        tick();
        chk("addi_back_fetch", state_dbg, ST_FETCH);

        // ---- LD with 3 wait states in MEM_LD ----
        set_ir(7'b0000011, 3'b011, 7'b0000000);
        tick();
        chk("ld_d_state",   state_dbg, ST_DECODE);
        tick();
        chk("ld_a_state",   state_dbg, ST_ADDR);
        chk("ld_a_imm",     imm_sel, 0);
        tick();
        u_if.mem_ready = 1'b0;
        #1;
        chk("ld_m1_state",  state_dbg, ST_MEM_LD);
        chk("ld_m1_req",    u_if.mem_req, 1);
        chk("ld_m1_wr",     u_if.mem_wr, 0);
        chk("ld_m1_mdr",    mdr_wr, 0);
        tick();
        chk("ld_m2_state",  state_dbg, ST_MEM_LD);
        chk("ld_m2_mdr",    mdr_wr, 0);
        tick();
        chk("ld_m3_state",  state_dbg, ST_MEM_LD);
        tick();
        u_if.mem_ready = 1'b1;
        #1;
        chk("ld_m4_state",  state_dbg, ST_MEM_LD);
        chk("ld_m4_req",    u_if.mem_req, 1);
        chk("ld_m4_mdr",    mdr_wr, 1);
        tick();
        chk("ld_wb_state",  state_dbg, ST_LD_WB);
        chk("ld_wb_reg_wr", reg_wr, 1);
        chk("ld_wb_m2r",    mem_to_reg, 1);
        chk("ld_wb_req",    u_if.mem_req, 0);
        tick();
        chk("ld_back_fetch", state_dbg, ST_FETCH);

        // ---- R-type SUB ----
        set_ir(7'b0110011, 3'b000, 7'b0100000);
        tick();
        tick();
        chk("sub_state",    state_dbg, ST_EXEC_R);
        chk("sub_alu_op",   alu_op, 1);
        chk("sub_src_b",    alu_src_b, 0);
        tick();
        chk("sub_wb_state", state_dbg, ST_ALU_WB);
        tick();

        // ---- BEQ taken ----
        set_ir(7'b1100011, 3'b000, 7'b0000000);
        alu_zero = 1'b1;
        tick();
        tick();
        chk("beq_state",    state_dbg, ST_BRANCH);
        chk("beq_pc_wr",    pc_wr, 1);
        chk("beq_pc_src",   pc_src, 1);
        chk("beq_alu_op",   alu_op, 1);
        tick();
        chk("beq_back_fetch", state_dbg, ST_FETCH);

        // ---- BNE with zero result: not taken ----
        set_ir(7'b1100011, 3'b001, 7'b0000000);
        tick();
        tick();
        chk("bne_state",    state_dbg, ST_BRANCH);
        chk("bne_pc_wr",    pc_wr, 0);
        chk("bne_pc_src",   pc_src, 1);
        tick();
        alu_zero = 1'b0;

        // ---- Illegal opcode ----
        set_ir(7'b1111111, 3'b000, 7'b0000000);
        tick();
        chk("ill_d_state",  state_dbg, ST_DECODE);
        tick();
        chk("ill_state",    state_dbg, ST_TRAP);
        chk("ill_trap",     trap, 1);
        chk("ill_cause",    trap_cause, 1);
        chk("ill_req",      u_if.mem_req, 0);
        repeat (100) tick();
        chk("ill_sticky_state", state_dbg, ST_TRAP);
        chk("ill_sticky_cause", trap_cause, 1);
        rst_n = 1'b0;
        #1;
        chk("ill_rst_state", state_dbg, ST_RESET);
        chk("ill_rst_trap",  trap, 0);
        chk("ill_rst_cause", trap_cause, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- Fetch timeout: 16 stall cycles then trap ----
        tick();
        u_if.mem_ready = 1'b0;
        #1;
        chk("to_f1_state", state_dbg, ST_FETCH);
        repeat (15) tick();
        chk("to_f16_state", state_dbg, ST_FETCH);
        chk("to_f16_trap",  trap, 0);
        tick();
        chk("to_state",    state_dbg, ST_TRAP);
        chk("to_cause",    trap_cause, 2);
        chk("to_trap",     trap, 1);
        reset_pulse();

        // ---- Ready on the 16th fetch cycle: access completes ----
        set_ir(7'b0100011, 3'b011, 7'b0000000);   // SD for the next phase
        tick();
        u_if.mem_ready = 1'b0;
        repeat (14) tick();
        chk("rw_f15_state", state_dbg, ST_FETCH);
        tick();
        u_if.mem_ready = 1'b1;
        #1;
        chk("rw_f16_ir_wr", ir_wr, 1);
        tick();
        chk("rw_state",     state_dbg, ST_DECODE);
        chk("rw_trap",      trap, 0);

        // ---- Store interrupted by reset ----
        tick();
        chk("sd_a_state",   state_dbg, ST_ADDR);
        chk("sd_a_imm",     imm_sel, 1);
        tick();
        u_if.mem_ready = 1'b0;
        #1;
        chk("sd_m_state",   state_dbg, ST_MEM_SD);
        chk("sd_m_req",     u_if.mem_req, 1);
        chk("sd_m_wr",      u_if.mem_wr, 1);
        rst_n = 1'b0;
        #1;
        chk("sd_rst_req",   u_if.mem_req, 0);
        chk("sd_rst_wr",    u_if.mem_wr, 0);
        chk("sd_rst_state", state_dbg, ST_RESET);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("sd_rel_state", state_dbg, ST_RESET);
        chk("sd_rel_wr",    u_if.mem_wr, 0);
        tick();
        chk("sd_restart_state", state_dbg, ST_FETCH);
        chk("sd_restart_wr",    u_if.mem_wr, 0);
        chk("sd_restart_req",   u_if.mem_req, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit reached");
    end

endmodule

// File: doc/main_control_fsm.md
# main_control_fsm

Multicycle control unit for the RV64 core: a Moore/Mealy state machine that sequences the shared datapath (PC, IR, register file, ALU, ALUOut, MDR, immediate extender, unified memory) one instruction at a time. It decodes the IR opcode and funct fields, drives every datapath enable and mux select, selects the immediate format for the sign extender, and runs a request/ready handshake with memory guarded by a timeout watchdog. Illegal instructions and memory timeouts park it in a sticky trap state.

## Interface
- MEM_TIMEOUT, 16: max consecutive stalled cycles per memory access; 0 disables the watchdog.
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  7  IR[6:0].
- funct3  in  3  IR[14:12].
- funct7  in  7  IR[31:25].
- alu_zero  in  1  ALU result == 0.
- mem_ready  in  1  memory completes the current access this cycle.
- mem_req  out  1  memory access request.
- mem_wr  out  1  1 = write (valid with mem_req); 0 = read.
- ir_wr  out  1  load IR and OldPC from memory/PC.
- pc_wr  out  1  PC write enable.
- pc_src  out  1  0 = ALU result, 1 = ALUOut.
- alu_src_a  out  2  0 PC, 1 regA, 2 OldPC, 3 zero.
- alu_src_b  out  2  0 regB, 1 const 4, 2 immediate.
- alu_op  out  3  000 ADD, 001 SUB.
- imm_sel  out  3  0 I, 1 S, 2 B, 3 U.
- alu_out_wr  out  1  ALUOut write enable.
- mdr_wr  out  1  MDR write enable.
- reg_wr  out  1  register file write enable.
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR.
- trap  out  1  sticky trap flag.
- trap_cause  out  2  0 none, 1 illegal instruction, 2 memory timeout.
- state_dbg  out  4  current state encoding.

## Operation
- States: S_RESET, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_EXEC_U, S_ALU_WB, S_ADDR, S_MEM_LD, S_LD_WB, S_MEM_SD, S_BRANCH, S_TRAP.
- Any output not listed for a state is 0.
- S_RESET: all outputs 0 → S_FETCH.
- S_FETCH: mem_req=1, mem_wr=0, alu_src_a=0, alu_src_b=1, alu_op=ADD. While mem_ready=0, stay. When mem_ready=1, same cycle: ir_wr=1, pc_wr=1, pc_src=0 (PC+4) → S_DECODE.
- S_DECODE: alu_src_a=2, alu_src_b=2, imm_sel=B, alu_out_wr=1 (branch target). Legal decode:
  - 0110011, funct3 000, funct7 0000000/0100000 → S_EXEC_R.
  - 0010011, funct3 000 → S_EXEC_I.
  - 0110111 → S_EXEC_U.
  - 0000011 or 0100011, funct3 011 → S_ADDR.
  - 1100011, funct3 000/001 → S_BRANCH.
  - Anything else → S_TRAP with cause 1.
- S_EXEC_R: a=1, b=0, alu_op = funct7[5] ? SUB : ADD, alu_out_wr=1 → S_ALU_WB.
- S_EXEC_I: a=1, b=2, imm_sel=I, ADD, alu_out_wr=1 → S_ALU_WB.
- S_EXEC_U: a=3, b=2, imm_sel=U, ADD, alu_out_wr=1 → S_ALU_WB.
- S_ALU_WB: reg_wr=1, mem_to_reg=0 → S_FETCH.
- S_ADDR: a=1, b=2, imm_sel = (opcode==0000011) ? I : S, ADD, alu_out_wr=1 → S_MEM_LD for a load, S_MEM_SD for a store.
- S_MEM_LD: mem_req=1, mem_wr=0. On mem_ready: mdr_wr=1 → S_LD_WB.
- S_LD_WB: reg_wr=1, mem_to_reg=1 → S_FETCH.
- S_MEM_SD: mem_req=1, mem_wr=1. On mem_ready → S_FETCH.
- S_BRANCH: a=1, b=0, SUB. pc_wr = (funct3==000 & alu_zero) | (funct3==001 & !alu_zero), pc_src=1 → S_FETCH.
- S_TRAP: all datapath enables 0, trap=1, trap_cause held; leaves only on reset.
- Watchdog:
  - Counter clears on every entry to S_FETCH/S_MEM_LD/S_MEM_SD.
  - Increments each cycle mem_req=1 & mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0 → S_TRAP, cause 2.
  - mem_ready=1 in that same cycle wins: the access completes, no trap.

## Timing
- State register, trap_cause and watchdog reset asynchronously on rst_n=0. Reset values: state=S_RESET, every output 0, state_dbg=S_RESET encoding.
- Outputs decode combinationally from state, IR fields, alu_zero and mem_ready.
- Cycles per instruction with zero-wait memory: R/ADDI/LUI 4, LD 5, SD 4, branch 3. Each stall cycle adds 1.
- Reset asserted mid-access drops mem_req in the same cycle (asynchronous). No partial writes are issued afterwards.
- IR fields must be stable from S_DECODE until return to S_FETCH; only S_FETCH asserts ir_wr.

## Structure
- ctrl_pkg:
  - state_t enum (4-bit).
  - Opcode constants OP_R, OP_ADDI, OP_LUI, OP_LD, OP_SD, OP_BR.
  - Encodings for alu_src_a/b, alu_op, imm_sel, trap_cause.
  - The sign extender uses the same IMM_* constants.
- Sub-module mem_timeout_ctr: parameter MEM_TIMEOUT; inputs clear/stall; output expired.

## Test plan
- Reset released, memory ready every cycle, IR = ADDI x1,x0,5 → states FETCH, DECODE, EXEC_I, ALU_WB. reg_wr=1 in cycle 4 only; pc_wr in cycle 1.
- LD with mem_ready delayed 3 cycles in S_MEM_LD → mem_req held 4 cycles. mdr_wr pulses only in the ready cycle. Total 8 cycles.
- BEQ with alu_zero=1 → pc_wr=1, pc_src=1 in S_BRANCH. Repeat as BNE with alu_zero=1 → pc_wr=0.
- Opcode 1111111 → S_TRAP after DECODE, trap=1, trap_cause=1. Stays for 100 cycles; rst_n pulse returns state to S_RESET.
- MEM_TIMEOUT=16, mem_ready never asserted in S_FETCH → trap with cause 2 after 16 stall cycles. Same test with ready on the 16th cycle → no trap.
- rst_n low in the middle of S_MEM_SD → mem_req and mem_wr go to 0 immediately. After release, fetch restarts via S_RESET.
